// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional trailer checksum is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DRAIN,
    DONE,
    ERROR
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  // Low byte-address bits that must be zero for a word-aligned base.
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'(WORD_BYTES - 1);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words; the word is presented
// with a one-cycle valid strobe the cycle after its fourth byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_fourth,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [31:0] r_shift;
  logic        r_word_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= 2'd0;
      r_shift      <= 32'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= i_valid && o_fourth;
      if (i_valid) begin
        r_shift <= {r_shift[23:0], i_data};
        r_cnt   <= r_cnt + 2'd1;
      end
    end
  end

  // The shift register still holds the finished word during the strobe cycle,
  // even if the next word's first byte arrives on that same cycle.
  assign o_fourth     = (r_cnt == 2'(WORD_BYTES - 1));
  assign o_word_valid = r_word_valid;
  assign o_word       = r_shift;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: header length, big-endian words, CPU release.
// Define IMEM_LOADER_CHECKSUM_EN to require an XOR trailer byte after the payload.
//
// state  | meaning
// LEN_HI | waiting for word-count high byte
// LEN_LO | waiting for word-count low byte
// DATA   | packing payload bytes, writing words
// CHECK  | waiting for the checksum trailer byte
// DRAIN  | one quiet cycle so the last write lands first
// DONE   | image loaded, CPU released
// ERROR  | overflow or bad checksum, CPU held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [31:0] BASE_AL   = BASE_ADDR & ~ADDR_ALIGN_MASK;
  localparam logic [16:0] CAP_WORDS = (ADDR_W >= 16) ? 17'h10000 : 17'(1 << ADDR_W);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_len;
  logic [15:0] r_word_idx;
  logic        r_rx_ready, w_ready_nxt;
  logic        r_ovf;
  logic        w_accept, w_pk_valid, w_fourth, w_word_valid;
  logic        w_in_range, w_last_byte, w_last_word, w_fail;
  logic [31:0] w_word;
  state_t      w_after_payload;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
  logic        r_csum_bad;
  assign w_after_payload = CHECK;
  assign w_fail          = r_ovf | r_csum_bad;
`else
  assign w_after_payload = DRAIN;
  assign w_fail          = r_ovf;
`endif

  assign w_accept     = rx_valid & r_rx_ready;
  assign w_pk_valid   = w_accept & (r_state == DATA);
  assign w_in_range   = ({1'b0, r_word_idx} < CAP_WORDS);
  assign w_last_byte  = w_pk_valid & w_fourth & (r_word_idx == r_len - 16'd1);
  assign w_last_word  = w_word_valid & (r_state == DATA) & (r_word_idx == r_len - 16'd1);

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (w_pk_valid),
    .i_data       (rx_data),
    .o_fourth     (w_fourth),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LEN_HI: if (w_accept) w_state_nxt = LEN_LO;
      LEN_LO: if (w_accept) w_state_nxt = ({r_len[15:8], rx_data} == 16'd0) ? w_after_payload : DATA;
      DATA:   if (w_last_word) w_state_nxt = w_after_payload;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK:  if (w_accept) w_state_nxt = DRAIN;
`endif
      DRAIN:  w_state_nxt = w_fail ? ERROR : DONE;
      DONE:   w_state_nxt = DONE;
      ERROR:  w_state_nxt = ERROR;
      default: w_state_nxt = LEN_HI;
    endcase
    // Stop accepting once the final payload byte is in, until the state moves on.
    w_ready_nxt = (w_state_nxt == LEN_HI || w_state_nxt == LEN_LO ||
                   w_state_nxt == DATA   || w_state_nxt == CHECK) && !w_last_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= LEN_HI;
      r_len      <= 16'd0;
      r_word_idx <= 16'd0;
      r_rx_ready <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rx_ready <= w_ready_nxt;
      if (w_accept && r_state == LEN_HI) r_len[15:8] <= rx_data;
      if (w_accept && r_state == LEN_LO) r_len[7:0]  <= rx_data;
      if (w_word_valid && r_state == DATA) begin
        r_word_idx <= r_word_idx + 16'd1;
        if (!w_in_range) r_ovf <= 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_csum     <= 8'd0;
      r_csum_bad <= 1'b0;
    end else begin
      if (w_pk_valid) r_csum <= r_csum ^ rx_data;
      if (w_accept && r_state == CHECK) r_csum_bad <= (rx_data != r_csum);
    end
  end
`endif

  assign rx_ready   = r_rx_ready;
  assign imem_we    = w_word_valid & (r_state == DATA) & w_in_range;
  assign imem_addr  = BASE_AL + 32'({r_word_idx, 2'b00});
  assign imem_wdata = w_word;
  assign cpu_reset  = (r_state != DONE);
  assign load_done  = (r_state == DONE);
  assign load_error = (r_state == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (capacity 4 words); honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int          ADDR_W = 2;
  localparam int          CAP    = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;

  typedef logic [7:0] bq_t[$];

  logic        clk, reset, rx_valid, rx_ready, imem_we, cpu_reset, load_done, load_error;
  logic [7:0]  rx_data;
  logic [31:0] imem_addr, imem_wdata;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0, last_we_cyc = -100, fall_cyc = -1;
  logic        prev_cr = 1'b1;
  logic [31:0] q_addr[$], q_data[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe pops the next expected (addr, data) pair.
  always @(negedge clk) begin
    cyc++;
    if (imem_we === 1'b1) begin
      last_we_cyc = cyc;
      if (q_addr.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", imem_addr, imem_wdata);
      end else begin
        chk("wr_addr", imem_addr, q_addr.pop_front());
        chk("wr_data", imem_wdata, q_data.pop_front());
      end
    end
    if (prev_cr === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
    prev_cr = cpu_reset;
  end

  // Reference model: which words reach memory, given the first 'upto' stream bytes.
  task automatic push_expect(input bq_t s, input int upto);
    int n;
    n = {s[0], s[1]};
    for (int i = 0; i < n; i++)
      if (i < CAP && 2 + 4*i + 4 <= upto) begin
        q_addr.push_back(BASE + 32'(4*i));
        q_data.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
      end
  endtask

  function automatic bit model_err(input bq_t s);
    int n;
    logic [7:0] x;
    n = {s[0], s[1]};
    x = 8'h00;
    for (int i = 0; i < 4*n; i++) x ^= s[2+i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    return (n > CAP) || (s[2+4*n] != x);
`else
    return (n > CAP);
`endif
  endfunction

  function automatic bq_t with_trailer(input bq_t s, input logic [7:0] flip);
    bq_t r;
    logic [7:0] x;
    r = s;
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 2; i < s.size(); i++) x ^= s[i];
    r.push_back(x ^ flip);
`else
    x = flip;
`endif
    return r;
  endfunction

  function automatic bq_t mk_random(input int n);
    bq_t s;
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom));
    return s;
  endfunction

  task automatic do_reset(input bit check_vals);
    @(posedge clk); #1;
    reset = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (check_vals) begin
      chk("rst_rx_ready", rx_ready, 0);
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, BASE);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_load_done", load_done, 0);
      chk("rst_load_error", load_error, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    fall_cyc = -1;
  endtask

  // gap: 0 back-to-back, 1 valid every other cycle, 2 three-cycle idle gaps, 3 random gaps
  task automatic send(input bq_t s, input int gap, input int nbytes);
    for (int k = 0; k < nbytes; k++) begin
      int idle;
      int t;
      logic ok;
      idle = 0;
      if (gap == 1 && k % 2 == 1) idle = 1;
      if (gap == 2 && k % 5 == 4) idle = 3;
      if (gap == 3) idle = $urandom_range(0, 2);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      repeat (idle) begin @(posedge clk); #1; end
      rx_valid = 1'b1;
      rx_data  = s[k];
      t = 0;
      do begin
        ok = rx_ready;
        @(posedge clk); #1;
        t++;
      end while (!ok && t < 50);
      if (!ok) begin
        n_cmp++;
        n_fail++;
        $display("FAIL byte_accept_timeout: byte %0d never accepted, expected acceptance", k);
        k = nbytes;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_image(input bq_t s, input int gap, input bit timing);
    bit e;
    do_reset(1'b0);
    e = model_err(s);
    push_expect(s, s.size());
    send(s, gap, s.size());
    for (int i = 0; i < 40 && !(load_done || load_error); i++) begin @(posedge clk); #1; end
    @(negedge clk); #1;
    chk("load_done", load_done, 32'(!e));
    chk("load_error", load_error, 32'(e));
    chk("cpu_reset", cpu_reset, 32'(e));
    chk("writes_left", q_addr.size(), 0);
    chk("rx_ready_final", rx_ready, 0);
    if (timing) chk("release_latency", fall_cyc - last_we_cyc, 2);
    q_addr.delete();
    q_data.delete();
  endtask

  bq_t s1, s;
  bit  tm;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    do_reset(1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    tm = 1'b0;
`else
    tm = 1'b1;
`endif
    s1 = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    run_image(with_trailer(s1, 8'h00), 0, tm);

    s = '{8'h00, 8'h00};
    run_image(with_trailer(s, 8'h00), 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_image(with_trailer(s, 8'h5A), 0, 1'b0);
`endif

    run_image(with_trailer(s1, 8'h00), 1, tm);
    run_image(with_trailer(s1, 8'h00), 2, tm);

    run_image(with_trailer(mk_random(5), 8'h00), 0, 1'b0);

    // Reset two bytes into the second word, then replay the whole image.
    do_reset(1'b0);
    push_expect(s1, 8);
    send(s1, 0, 8);
    repeat (3) @(posedge clk);
    do_reset(1'b1);
    chk("writes_left_mid_reset", q_addr.size(), 0);
    run_image(with_trailer(s1, 8'h00), 0, tm);

    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    run_image(with_trailer(s, 8'h00), 0, tm);
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_image(with_trailer(s, 8'h01), 0, 1'b0);
`endif

    for (int it = 0; it < 12; it++) begin
      int n;
      logic [7:0] flip;
      n = $urandom_range(0, 6);
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_image(with_trailer(mk_random(n), flip), $urandom_range(0, 3), tm && n > 0 && n <= CAP);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU's instruction memory; the CPU only ever reads instruction memory.
- Accepts a byte stream (from a UART receiver or testbench) over a valid/ready handshake.
- Assembles the stream into 32-bit big-endian words and writes them sequentially into the instruction memory write port.
- Holds the CPU in reset until the image is fully written, then releases it.

Parameters:
- ADDR_W, 8, word-address bits of instruction memory; capacity is 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  rx_data holds a byte
- rx_data  in  8  stream byte
- rx_ready  out  1  loader can accept a byte; a byte transfers on any cycle with rx_valid & rx_ready
- imem_we  out  1  instruction memory write strobe, one-cycle pulse per word
- imem_addr  out  32  byte address of the write; word-aligned
- imem_wdata  out  32  word to write
- cpu_reset  out  1  drives the CPU's pc_reset; high until the load completes
- load_done  out  1  image written, CPU released
- load_error  out  1  load failed; CPU held in reset

Behaviour:
- Reset values: state=LEN_HI, rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, byte and word counters=0.
- Reset is honoured in every state, including mid-word and mid-header. A partial word is discarded and no write strobe is issued.
- Stream format: 2-byte word count N (MSB first), then N words of 4 bytes each, MSB first (byte0 → wdata[31:24]).
- States:
  - LEN_HI: accept byte → len[15:8]; go to LEN_LO.
  - LEN_LO: accept byte → len[7:0]. If N==0, go to DRAIN (no writes); else go to DATA.
  - DATA: accept bytes into the packer. On the 4th byte, the next cycle has imem_we=1, imem_addr=BASE_ADDR + 4*word_idx, imem_wdata=packed word, and word_idx increments. After the Nth word, go to DRAIN (CHECK when CHECKSUM_EN is defined).
  - DRAIN: one cycle, rx_ready=0, so the final write lands before the CPU starts. Then go to DONE, or to ERROR if the overflow flag is set.
  - DONE: cpu_reset=0, load_done=1, rx_ready=0. Terminal until reset; no reload.
  - ERROR: cpu_reset=1, load_error=1, rx_ready=0. Terminal until reset.
- rx_ready=1 in LEN_HI, LEN_LO, DATA and CHECK; 0 otherwise. rx_ready is registered and does not depend combinationally on rx_valid.
- Write latency is exactly one cycle after the 4th byte's transfer cycle. A byte may transfer in the same cycle as a write pulse, so back-to-back bytes are sustained at one byte per cycle.
- Capacity: when N > 2^ADDR_W, words with index ≥ 2^ADDR_W are consumed without asserting imem_we, and the overflow flag is set. Addresses never wrap.
- cpu_reset falls on the same edge that load_done rises; both stay stable afterwards.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - One trailer byte follows the payload, accepted in state CHECK.
  - It must equal the XOR of all 4N payload bytes; header bytes are excluded.
  - Mismatch sets load_error via DRAIN → ERROR.
  - For N==0 the trailer is still required and must be 8'h00.
- Undefined: no trailer byte and no CHECK state; load_error reflects overflow only.

Decomposition:
- Package imem_loader_pkg:
  - state enum: LEN_HI, LEN_LO, DATA, CHECK, DRAIN, DONE, ERROR
  - HDR_BYTES=2
  - WORD_BYTES=4
  - BASE_ADDR alignment check constant
- Sub-module byte_packer:
  - 2-bit byte counter plus 32-bit shift register.
  - Emits word_valid with the word one cycle after the 4th byte.
  - Clears on reset.

Test Plan:
1. N=2, bytes 00 02 | DE AD BE EF | 01 23 45 67, one per cycle. Expect writes (0x0, DEADBEEF) then (0x4, 01234567); cpu_reset falls 2 cycles after the last write pulse cycle; load_done=1.
2. N=0 (00 00). Expect no imem_we, DONE after DRAIN; with the macro defined, send trailer 00 → done, trailer 5A → load_error=1, cpu_reset=1.
3. Same image as 1 with rx_valid toggling every other cycle and idle gaps of 3 cycles. Expect identical writes and addresses; no write before the 4th byte of each word.
4. ADDR_W=2, N=5. Expect exactly 4 writes at 0x0–0xC, the 5th word consumed without a write, load_error=1, load_done=0.
5. Assert reset after 2 bytes of word 1 in scenario 1, then replay the full stream. Expect no spurious write and a clean re-load identical to scenario 1.
6. Checksum enabled, N=1, payload 11 22 33 44, trailer 44 (0x11^0x22^0x33^0x44). Expect done; trailer 45 → error.
